// File: rtl/cnn1d_pkg.sv
`default_nettype none
// ============================================================================
//  Package : cnn1d_pkg
//  Shared types, fixed-point helpers and default ROM contents for the cnn1d
//  inference pipeline. Arithmetic helpers support data widths up to MAX_W.
//  Revision: 1.0 - initial release
// ============================================================================
package cnn1d_pkg;

  localparam int MAX_W  = 32;
  localparam int PROD_W = 2 * MAX_W;

  // Salts for the built-in ROM images used when no init file is supplied
  localparam logic [MAX_W-1:0] W_SALT = 32'h1357_9BDF;
  localparam logic [MAX_W-1:0] B_SALT = 32'h2468_ACE1;

  typedef logic signed [MAX_W-1:0] data_t;

  // Full-precision signed product, arithmetic shift right by the fraction
  // width (rounds toward -inf), low MAX_W bits kept.
  function automatic logic [MAX_W-1:0] fx_mul(input data_t a, input data_t b,
                                              input int frac);
    logic signed [PROD_W-1:0] p;
    p = a * b;
    return MAX_W'(p >>> frac);
  endfunction

  // Levels of a binary adder tree summing the taps plus the bias term
  function automatic int adder_tree_depth(input int filter_size);
    return $clog2(filter_size + 1);
  endfunction

  // Deterministic ROM word: idx * golden-ratio constant + salt (mod 2^MAX_W)
  function automatic logic [MAX_W-1:0] rom_default(input int idx,
                                                   input logic [MAX_W-1:0] salt);
    logic [MAX_W-1:0] x;
    x = MAX_W'(idx);
    return x * MAX_W'(32'h9E37_79B9) + salt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv1d_layer_filter.sv
`default_nettype none
// ============================================================================
//  Module  : conv1d_filter
//  One convolution filter: pipelined fixed-point tap multipliers followed by a
//  registered, zero-padded binary adder tree that also folds in the bias.
//  Revision: 1.0 - initial release
// ============================================================================
module conv1d_filter
  import cnn1d_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int FILTER_SIZE = 5,
  parameter int PIPE_WIDTH  = 4,
  parameter int FRACTION    = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] window  [FILTER_SIZE],
  input  logic                  win_valid,
  input  logic [DATA_WIDTH-1:0] weights [FILTER_SIZE],
  input  logic [DATA_WIDTH-1:0] bias,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  result_valid
);

  localparam int NOPS  = FILTER_SIZE + 1;
  localparam int DEPTH = adder_tree_depth(FILTER_SIZE);

  logic [DATA_WIDTH-1:0] mul_pipe  [PIPE_WIDTH][FILTER_SIZE];
  logic                  mul_valid [PIPE_WIDTH];
  logic [DATA_WIDTH-1:0] lvl0      [2*NOPS];
  logic [DATA_WIDTH-1:0] tree      [DEPTH][2*NOPS];
  logic                  tree_valid[DEPTH];

  // Multiply in the first stage, then carry products through the remaining stages
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < PIPE_WIDTH; s++) begin
        mul_valid[s] <= 1'b0;
        for (int k = 0; k < FILTER_SIZE; k++) mul_pipe[s][k] <= '0;
      end
    end else if (en) begin
      mul_valid[0] <= win_valid;
      for (int k = 0; k < FILTER_SIZE; k++)
        mul_pipe[0][k] <= DATA_WIDTH'(fx_mul(MAX_W'($signed(window[k])),
                                             MAX_W'($signed(weights[k])), FRACTION));
      for (int s = 1; s < PIPE_WIDTH; s++) begin
        mul_valid[s] <= mul_valid[s-1];
        for (int k = 0; k < FILTER_SIZE; k++) mul_pipe[s][k] <= mul_pipe[s-1][k];
      end
    end
  end

  // Tree leaves: products, bias, then zero padding so every pair is defined
  always_comb begin
    for (int i = 0; i < 2*NOPS; i++) lvl0[i] = '0;
    for (int k = 0; k < FILTER_SIZE; k++) lvl0[k] = mul_pipe[PIPE_WIDTH-1][k];
    lvl0[FILTER_SIZE] = bias;
  end

  // Pairwise registered reduction; sums wrap in DATA_WIDTH bits
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int l = 0; l < DEPTH; l++) begin
        tree_valid[l] <= 1'b0;
        for (int i = 0; i < 2*NOPS; i++) tree[l][i] <= '0;
      end
    end else if (en) begin
      tree_valid[0] <= mul_valid[PIPE_WIDTH-1];
      for (int i = 0; i < NOPS; i++) tree[0][i] <= lvl0[2*i] + lvl0[2*i+1];
      for (int l = 1; l < DEPTH; l++) begin
        tree_valid[l] <= tree_valid[l-1];
        for (int i = 0; i < NOPS; i++) tree[l][i] <= tree[l-1][2*i] + tree[l-1][2*i+1];
      end
    end
  end

  assign result       = tree[DEPTH-1][0];
  assign result_valid = tree_valid[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/conv1d_layer.sv
`default_nettype none
// ============================================================================
//  Module  : conv1d_layer
//  First 1-D convolution layer: sliding sample window shared by NUM_FILTERS
//  pipelined filters, each producing bias + dot(weights, window).
//  Revision: 1.0 - initial release
// ============================================================================
module conv1d_layer
  import cnn1d_pkg::*;
#(
  parameter int DATA_WIDTH        = 32,
  parameter     WEIGHTS_INIT_FILE = "",
  parameter     BIASES_INIT_FILE  = "",
  parameter int NUM_FILTERS       = 32,
  parameter int FILTER_SIZE       = 5,
  parameter int PIPE_WIDTH        = 4,
  parameter int FRACTION          = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   conv1d_layer_ready_in,
  input  logic                   conv1d_layer_valid_in,
  input  logic [DATA_WIDTH-1:0]  conv1d_layer_data_in,
  input  logic                   conv1d_layer_ready_out,
  output logic [NUM_FILTERS-1:0] conv1d_layer_valid_out,
  output logic [DATA_WIDTH-1:0]  conv1d_layer_data_out [0:NUM_FILTERS-1]
);

  localparam int FILL_W = $clog2(FILTER_SIZE + 1);

  logic [DATA_WIDTH-1:0] weights_rom [NUM_FILTERS*FILTER_SIZE];
  logic [DATA_WIDTH-1:0] biases_rom  [NUM_FILTERS];
  logic [DATA_WIDTH-1:0] window      [FILTER_SIZE];
  logic [FILL_W-1:0]     fill;
  logic                  win_valid;
  logic                  en;
  logic                  accept;

  // Downstream ready gates the whole pipe; nothing is accepted during reset
  assign en                    = conv1d_layer_ready_out;
  assign conv1d_layer_ready_in = en & rst;
  assign accept                = conv1d_layer_valid_in & conv1d_layer_ready_in;

  for (genvar i = 0; i < NUM_FILTERS*FILTER_SIZE; i++) begin : g_w_word
    assign weights_rom[i] = DATA_WIDTH'(rom_default(i, W_SALT));
  end

  for (genvar i = 0; i < NUM_FILTERS; i++) begin : g_b_word
    assign biases_rom[i] = DATA_WIDTH'(rom_default(i, B_SALT));
  end

  // Shift window on accept; launch a result once the window has been filled
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < FILTER_SIZE; k++) window[k] <= '0;
      fill      <= '0;
      win_valid <= 1'b0;
    end else if (en) begin
      win_valid <= accept && (fill == FILL_W'(FILTER_SIZE - 1));
      if (accept) begin
        for (int k = 0; k < FILTER_SIZE - 1; k++) window[k] <= window[k+1];
        window[FILTER_SIZE-1] <= conv1d_layer_data_in;
        if (fill != FILL_W'(FILTER_SIZE - 1)) fill <= fill + 1'b1;
      end
    end
  end

  for (genvar f = 0; f < NUM_FILTERS; f++) begin : g_filter
    logic [DATA_WIDTH-1:0] taps [FILTER_SIZE];

    for (genvar k = 0; k < FILTER_SIZE; k++) begin : g_tap
      assign taps[k] = weights_rom[f*FILTER_SIZE + k];
    end

    conv1d_filter #(
      .DATA_WIDTH  (DATA_WIDTH),
      .FILTER_SIZE (FILTER_SIZE),
      .PIPE_WIDTH  (PIPE_WIDTH),
      .FRACTION    (FRACTION)
    ) u_filter (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .window       (window),
      .win_valid    (win_valid),
      .weights      (taps),
      .bias         (biases_rom[f]),
      .result       (conv1d_layer_data_out[f]),
      .result_valid (conv1d_layer_valid_out[f])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_conv1d_layer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module  : tb_conv1d_layer
//  Self-checking bench for conv1d_layer with a transaction-level model:
//  accepted samples feed a software window, results are queued with the
//  enabled-cycle index at which they must appear.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_conv1d_layer;

  localparam int DW   = 32;
  localparam int NF   = 32;
  localparam int FS   = 5;
  localparam int PW   = 4;
  localparam int FRAC = 24;
  localparam int LAT  = 1 + PW + $clog2(FS + 1);

  typedef logic [NF-1:0][DW-1:0] pvec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ready_in;
  logic          valid_in = 1'b0;
  logic          ready_out = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [NF-1:0] valid_out;
  logic [DW-1:0] data_out [0:NF-1];

  int tests    = 0;
  int failures = 0;

  // Reference model state
  logic [DW-1:0] hist[$];
  int            accepts;
  int            en_cnt;
  int            tgt_q[$];
  pvec_t         res_q[$];
  logic          m_valid;
  pvec_t         m_data;

  always #5 clk = ~clk;

  conv1d_layer #(
    .DATA_WIDTH  (DW),
    .NUM_FILTERS (NF),
    .FILTER_SIZE (FS),
    .PIPE_WIDTH  (PW),
    .FRACTION    (FRAC)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .conv1d_layer_ready_in  (ready_in),
    .conv1d_layer_valid_in  (valid_in),
    .conv1d_layer_data_in   (data_in),
    .conv1d_layer_ready_out (ready_out),
    .conv1d_layer_valid_out (valid_out),
    .conv1d_layer_data_out  (data_out)
  );

  // Built-in ROM images: word = index * 0x9E3779B9 + salt (mod 2^32)
  function automatic logic [31:0] w_of(input int f, input int k);
    logic [31:0] idx;
    idx = 32'(f*FS + k);
    return idx * 32'h9E37_79B9 + 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] b_of(input int f);
    logic [31:0] idx;
    idx = 32'(f);
    return idx * 32'h9E37_79B9 + 32'h2468_ACE1;
  endfunction

  // bias + sum of floor(x*w / 2^FRAC), all modulo 2^32; hist[0] is oldest
  function automatic pvec_t model_out();
    pvec_t r;
    for (int f = 0; f < NF; f++) begin
      logic [31:0] acc;
      acc = b_of(f);
      for (int k = 0; k < FS; k++) begin
        longint p;
        p = longint'($signed(hist[k])) * longint'($signed(w_of(f, k)));
        p = p >>> FRAC;
        acc = acc + p[31:0];
      end
      r[f] = acc;
    end
    return r;
  endfunction

  task automatic model_clear();
    hist.delete();
    tgt_q.delete();
    res_q.delete();
    accepts = 0;
    en_cnt  = 0;
    m_valid = 1'b0;
    m_data  = '0;
  endtask

  // Hold reset for n edges; returns #1 after the last edge with rst still low
  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b0; valid_in = 1'b0; ready_out = 1'b1; data_in = '0;
    repeat (n) @(posedge clk);
    #1;
    model_clear();
  endtask

  // Drive one cycle (releasing reset), advance the model, return expectations
  task automatic cycle(input logic v, input logic r, input logic [DW-1:0] d,
                       output logic exp_v, output pvec_t exp_d);
    @(negedge clk);
    rst = 1'b1; valid_in = v; ready_out = r; data_in = d;
    @(posedge clk);
    if (r) begin
      if (v) begin
        hist.push_back(d);
        if (hist.size() > FS) void'(hist.pop_front());
        accepts++;
        if (accepts >= FS) begin
          tgt_q.push_back(en_cnt + LAT - 1);
          res_q.push_back(model_out());
        end
      end
      if (tgt_q.size() > 0 && tgt_q[0] == en_cnt) begin
        void'(tgt_q.pop_front());
        m_valid = 1'b1;
        m_data  = res_q.pop_front();
      end else begin
        m_valid = 1'b0;
      end
      en_cnt++;
    end
    #1;
    exp_v = m_valid;
    exp_d = m_data;
  endtask

  task automatic test_reset();
    do_reset(3);
    tests++;
    if (valid_out !== '0) begin
      failures++; $display("FAIL reset_valid: got %h want 0", valid_out);
    end
    tests++;
    if (ready_in !== 1'b0) begin
      failures++; $display("FAIL reset_ready_in: got %b want 0", ready_in);
    end
    for (int f = 0; f < NF; f++) begin
      tests++;
      if (data_out[f] !== '0) begin
        failures++; $display("FAIL reset_data[%0d]: got %h want 0", f, data_out[f]);
      end
    end
  endtask

  task automatic test_constant();
    logic ev; pvec_t ed; int first;
    first = -1;
    do_reset(2);
    for (int i = 0; i < 24; i++) begin
      cycle(1'b1, 1'b1, 32'hFFF7_3556, ev, ed);
      if (valid_out[0] === 1'b1 && first < 0) first = i + 1;
      tests++;
      if (valid_out !== {NF{ev}}) begin
        failures++; $display("FAIL const_valid cyc %0d: got %h want %h", i, valid_out, {NF{ev}});
      end
      if (ev) for (int f = 0; f < NF; f++) begin
        tests++;
        if (data_out[f] !== ed[f]) begin
          failures++; $display("FAIL const_data cyc %0d f %0d: got %h want %h", i, f, data_out[f], ed[f]);
        end
      end
    end
    tests++;
    if (first !== FS - 1 + LAT) begin
      failures++; $display("FAIL const_first_valid: got cycle %0d want %0d", first, FS - 1 + LAT);
    end
  endtask

  task automatic test_impulse();
    logic ev; pvec_t ed; int j; logic [31:0] want;
    j = 0;
    do_reset(1);
    for (int i = 0; i < 4 + 1 + 6 + LAT; i++) begin
      cycle(i < 11, 1'b1, (i == 4) ? 32'h0100_0000 : 32'h0, ev, ed);
      tests++;
      if (valid_out !== {NF{ev}}) begin
        failures++; $display("FAIL impulse_valid cyc %0d: got %h want %h", i, valid_out, {NF{ev}});
      end
      if (ev) begin
        for (int f = 0; f < NF; f++) begin
          want = (j < FS) ? b_of(f) + w_of(f, FS - 1 - j) : b_of(f);
          tests++;
          if (data_out[f] !== want) begin
            failures++; $display("FAIL impulse_data out %0d f %0d: got %h want %h", j, f, data_out[f], want);
          end
        end
        j++;
      end
    end
    tests++;
    if (j !== 7) begin
      failures++; $display("FAIL impulse_count: got %0d want 7", j);
    end
  endtask

  task automatic test_backpressure();
    logic ev; pvec_t ed; logic r; int seen; int acc_total;
    seen = 0;
    do_reset(1);
    for (int i = 0; i < 10 + 5 + 12 + LAT; i++) begin
      r = !(i >= 10 && i < 15);
      cycle(i < 27, r, $urandom(), ev, ed);
      if (valid_out[0] === 1'b1 && r) seen++;
      tests++;
      if (ready_in !== r) begin
        failures++; $display("FAIL bp_ready_in cyc %0d: got %b want %b", i, ready_in, r);
      end
      tests++;
      if (valid_out !== {NF{ev}}) begin
        failures++; $display("FAIL bp_valid cyc %0d: got %h want %h", i, valid_out, {NF{ev}});
      end
      if (ev) for (int f = 0; f < NF; f++) begin
        tests++;
        if (data_out[f] !== ed[f]) begin
          failures++; $display("FAIL bp_data cyc %0d f %0d: got %h want %h", i, f, data_out[f], ed[f]);
        end
      end
    end
    acc_total = 22;  // 27 valid cycles minus 5 stalled
    tests++;
    if (seen !== acc_total - (FS - 1)) begin
      failures++; $display("FAIL bp_result_count: got %0d want %0d", seen, acc_total - (FS - 1));
    end
  endtask

  task automatic test_bubbles();
    logic ev; pvec_t ed;
    do_reset(1);
    for (int i = 0; i < 30; i++) begin
      cycle((i % 2) == 0, 1'b1, $urandom(), ev, ed);
      tests++;
      if (valid_out !== {NF{ev}}) begin
        failures++; $display("FAIL bubble_valid cyc %0d: got %h want %h", i, valid_out, {NF{ev}});
      end
      if (ev) for (int f = 0; f < NF; f++) begin
        tests++;
        if (data_out[f] !== ed[f]) begin
          failures++; $display("FAIL bubble_data cyc %0d f %0d: got %h want %h", i, f, data_out[f], ed[f]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic ev; pvec_t ed; logic [DW-1:0] d;
    do_reset(1);
    for (int i = 0; i < 20; i++) begin
      d = (i == 7) ? 32'h8000_0000 : 32'h7FFF_FFFF;
      cycle(1'b1, 1'b1, d, ev, ed);
      tests++;
      if (valid_out !== {NF{ev}}) begin
        failures++; $display("FAIL ovf_valid cyc %0d: got %h want %h", i, valid_out, {NF{ev}});
      end
      if (ev) for (int f = 0; f < NF; f++) begin
        tests++;
        if (data_out[f] !== ed[f]) begin
          failures++; $display("FAIL ovf_data cyc %0d f %0d: got %h want %h", i, f, data_out[f], ed[f]);
        end
      end
    end
  endtask

  task automatic test_random_midreset();
    logic ev; pvec_t ed;
    do_reset(1);
    for (int i = 0; i < 60; i++) begin
      if (i == 25) begin
        do_reset(1);
        tests++;
        if (valid_out !== '0 || data_out[0] !== '0 || ready_in !== 1'b0) begin
          failures++;
          $display("FAIL midreset_state: got valid %h data0 %h rdy %b want 0 0 0",
                   valid_out, data_out[0], ready_in);
        end
      end
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8, $urandom(), ev, ed);
      tests++;
      if (valid_out !== {NF{ev}}) begin
        failures++; $display("FAIL rand_valid cyc %0d: got %h want %h", i, valid_out, {NF{ev}});
      end
      if (ev) for (int f = 0; f < NF; f++) begin
        tests++;
        if (data_out[f] !== ed[f]) begin
          failures++; $display("FAIL rand_data cyc %0d f %0d: got %h want %h", i, f, data_out[f], ed[f]);
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    model_clear();
    test_reset();
    test_constant();
    test_impulse();
    test_backpressure();
    test_bubbles();
    test_overflow();
    test_random_midreset();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
`default_nettype wire
